// File: rtl/fluxo_dados_exp7_pkg.sv
// Shared widths, memory depth and default timing parameters for the
// memory-sequence game datapath.
package fluxo_dados_exp7_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 4;
    localparam int MEM_DEPTH = 16;

    localparam logic [DATA_W-1:0] JOGADA_INICIAL_DEF = 4'b0001;

    localparam int TIMEOUT_DEF   = 5000;
    localparam int TEMPO_LED_DEF = 1000;
    localparam int N_RODADAS_DEF = 16;

    // Width of a counter that reaches m-1; a 1-state counter still needs one bit.
    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/fluxo_dados_exp7_if.sv
// Control/status bundle between the game control unit (master) and the
// datapath (slave), plus the debug taps used to observe the counters.
interface fluxo_dados_exp7_if #(
    parameter int TIMEOUT   = fluxo_dados_exp7_pkg::TIMEOUT_DEF,
    parameter int TEMPO_LED = fluxo_dados_exp7_pkg::TEMPO_LED_DEF
);
    import fluxo_dados_exp7_pkg::*;

    localparam int T_W = cnt_width(TIMEOUT);
    localparam int P_W = cnt_width(TEMPO_LED);

    // Level-sensitive commands sampled on every rising clock edge; jogada is a
    // one-cycle pulse with no acknowledge, all other status flags are levels.
    logic [DATA_W-1:0] botoes;
    logic              zeraE, contaE;
    logic              zeraRod, contaRod;
    logic              zeraT, contaT;
    logic              zeraP, contaP;
    logic              zeraR, registraR;
    logic              we;
    logic              sinal_led;

    logic              jogada;
    logic              igual;
    logic              enderecoIgualRodada;
    logic              fimE, fimRod, fimT, fimP;
    logic [DATA_W-1:0] leds;
    logic [ADDR_W-1:0] db_contagem;
    logic [ADDR_W-1:0] db_rodada;
    logic [DATA_W-1:0] db_jogada;
    logic [DATA_W-1:0] db_memoria;
    logic [T_W-1:0]    db_tempo;
    logic [P_W-1:0]    db_tempo_led;

    modport master (
        output botoes, zeraE, contaE, zeraRod, contaRod, zeraT, contaT,
               zeraP, contaP, zeraR, registraR, we, sinal_led,
        input  jogada, igual, enderecoIgualRodada, fimE, fimRod, fimT, fimP,
               leds, db_contagem, db_rodada, db_jogada, db_memoria,
               db_tempo, db_tempo_led
    );

    modport slave (
        input  botoes, zeraE, contaE, zeraRod, contaRod, zeraT, contaT,
               zeraP, contaP, zeraR, registraR, we, sinal_led,
        output jogada, igual, enderecoIgualRodada, fimE, fimRod, fimT, fimP,
               leds, db_contagem, db_rodada, db_jogada, db_memoria,
               db_tempo, db_tempo_led
    );

endinterface

// File: rtl/fluxo_dados_exp7_contador.sv
// Generic modulo-M counter with synchronous clear/enable; SATURA selects
// hold-at-terminal instead of wrap.
module contador_m
    import fluxo_dados_exp7_pkg::*;
#(
    parameter int M      = 16,
    parameter bit SATURA = 1'b0,
    parameter int W      = cnt_width(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    localparam logic [W-1:0] MAX = W'(M - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Q <= '0;
        end else if (zera) begin
            Q <= '0;
        end else if (conta) begin
            if (Q == MAX) Q <= SATURA ? MAX : '0;
            else          Q <= Q + 1'b1;
        end
    end

    assign fim = (Q == MAX);

endmodule

// File: rtl/fluxo_dados_exp7_edge.sv
// Rising-edge detector for the button-pressed level; registered pulse output
// gives two cycles from input change to pulse.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    logic atual;
    logic anterior;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            atual    <= 1'b0;
            anterior <= 1'b0;
            pulso    <= 1'b0;
        end else begin
            atual    <= entrada;
            anterior <= atual;
            pulso    <= atual & ~anterior;
        end
    end

endmodule

// File: rtl/fluxo_dados_exp7_ram.sv
// 16x4 sequence memory: asynchronous read, synchronous write, plus a
// dedicated port that seeds word 0 with the initial play.
module sync_ram_16x4
    import fluxo_dados_exp7_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] endereco,
    input  logic [DATA_W-1:0] dadoEntrada,
    input  logic              escreveInicial,
    input  logic [DATA_W-1:0] dadoInicial,
    output logic [DATA_W-1:0] dadoSaida
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // The seed write is placed last so it wins when both target word 0.
    always_ff @(posedge clock) begin
        if (we)             mem[endereco] <= dadoEntrada;
        if (escreveInicial) mem[0]        <= dadoInicial;
    end

    assign dadoSaida = mem[endereco];

endmodule

// File: rtl/fluxo_dados_exp7.sv
// Datapath of the memory-sequence game: counters, play register, sequence
// memory, comparator and button edge detector.
module fluxo_dados_exp7
    import fluxo_dados_exp7_pkg::*;
#(
    parameter int                TIMEOUT        = TIMEOUT_DEF,
    parameter int                TEMPO_LED      = TEMPO_LED_DEF,
    parameter int                N_RODADAS      = N_RODADAS_DEF,
    parameter logic [DATA_W-1:0] JOGADA_INICIAL = JOGADA_INICIAL_DEF
) (
    input  logic               clock,
    input  logic               reset,
    fluxo_dados_exp7_if.slave  dp
);

    localparam int T_W = cnt_width(TIMEOUT);
    localparam int P_W = cnt_width(TEMPO_LED);

    logic [ADDR_W-1:0] contagem;
    logic [ADDR_W-1:0] rodada;
    logic [T_W-1:0]    tempo;
    logic [P_W-1:0]    tempoLed;
    logic [DATA_W-1:0] registroJogada;
    logic [DATA_W-1:0] dadoMemoria;
    logic              fimRodada;

    contador_m #(.M(MEM_DEPTH)) contadorE (
        .clock(clock), .reset(reset), .zera(dp.zeraE), .conta(dp.contaE),
        .Q(contagem), .fim(dp.fimE)
    );

    contador_m #(.M(MEM_DEPTH)) contadorRod (
        .clock(clock), .reset(reset), .zera(dp.zeraRod), .conta(dp.contaRod),
        .Q(rodada), .fim(fimRodada)
    );

    contador_m #(.M(TIMEOUT), .SATURA(1'b1)) contadorT (
        .clock(clock), .reset(reset), .zera(dp.zeraT), .conta(dp.contaT),
        .Q(tempo), .fim(dp.fimT)
    );

    contador_m #(.M(TEMPO_LED), .SATURA(1'b1)) contadorP (
        .clock(clock), .reset(reset), .zera(dp.zeraP), .conta(dp.contaP),
        .Q(tempoLed), .fim(dp.fimP)
    );

    // Round counter always spans the full address range; a shorter game
    // ends at its own terminal round.
    assign dp.fimRod = (N_RODADAS == MEM_DEPTH) ? fimRodada
                                                : (rodada == ADDR_W'(N_RODADAS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)             registroJogada <= '0;
        else if (dp.zeraR)     registroJogada <= '0;
        else if (dp.registraR) registroJogada <= dp.botoes;
    end

    sync_ram_16x4 memoria (
        .clock(clock),
        .we(dp.we),
        .endereco(contagem),
        .dadoEntrada(registroJogada),
        .escreveInicial(dp.zeraR),
        .dadoInicial(JOGADA_INICIAL),
        .dadoSaida(dadoMemoria)
    );

    edge_detector detectorBotao (
        .clock(clock),
        .reset(reset),
        .entrada(|dp.botoes),
        .pulso(dp.jogada)
    );

    assign dp.igual               = (dadoMemoria == registroJogada);
    assign dp.enderecoIgualRodada = (contagem == rodada);
    assign dp.leds                = dp.sinal_led ? memoria.mem[0] : dp.botoes;

    assign dp.db_contagem  = contagem;
    assign dp.db_rodada    = rodada;
    assign dp.db_jogada    = registroJogada;
    assign dp.db_memoria   = dadoMemoria;
    assign dp.db_tempo     = tempo;
    assign dp.db_tempo_led = tempoLed;

endmodule

// File: tb/tb_fluxo_dados_exp7.sv
// Self-checking bench for the memory-game datapath: directed sequences,
// a leds vector table and a write/read-back scoreboard over the memory.
module tb_fluxo_dados_exp7;
    import fluxo_dados_exp7_pkg::*;

    logic clock = 1'b0;
    logic reset;

    fluxo_dados_exp7_if bus ();

    fluxo_dados_exp7 dut (
        .clock(clock),
        .reset(reset),
        .dp(bus)
    );

    always #5 clock = ~clock;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [15:0] exp_q [$];
    logic [3:0]  val;

    typedef struct {
        logic [3:0] botoes;
        logic       sinal_led;
        logic [3:0] exp_leds;
    } led_vec_t;

    led_vec_t led_tab [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else             pass_cnt++;
    endtask

    task automatic chk_pop(input string name, input logic [15:0] act);
        if (exp_q.size() == 0) begin
            check_cnt++;
            $display("FAIL %s: got %0h expected <empty queue> at %0t", name, act, $time);
        end else begin
            chk(name, act, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.zeraE = 0; bus.contaE = 0; bus.zeraRod = 0; bus.contaRod = 0;
        bus.zeraT = 0; bus.contaT = 0; bus.zeraP = 0; bus.contaP = 0;
        bus.zeraR = 0; bus.registraR = 0; bus.we = 0; bus.sinal_led = 0;
    endtask

    task automatic load_reg(input logic [3:0] b);
        bus.botoes = b; bus.registraR = 1;
        tick();
        bus.registraR = 0; bus.botoes = 4'b0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        led_tab[0] = '{4'b0000, 1'b0, 4'b0000};
        led_tab[1] = '{4'b1000, 1'b0, 4'b1000};
        led_tab[2] = '{4'b0110, 1'b0, 4'b0110};
        led_tab[3] = '{4'b1111, 1'b0, 4'b1111};
        led_tab[4] = '{4'b1000, 1'b1, 4'b0001};
        led_tab[5] = '{4'b0000, 1'b1, 4'b0001};

        reset = 1; bus.botoes = 4'b0000; idle();
        #2;
        chk("reset_E", 16'(bus.db_contagem), 0);
        chk("reset_jogada", 16'(bus.jogada), 0);
        tick();
        reset = 0;

        // Load nonzero state everywhere, then reset between clock edges
        bus.botoes = 4'b0100; bus.registraR = 1;
        bus.contaE = 1; bus.contaRod = 1; bus.contaT = 1; bus.contaP = 1;
        tick();
        bus.registraR = 0;
        tick();
        chk("pre_reset_E", 16'(bus.db_contagem), 2);
        chk("pre_reset_T", 16'(bus.db_tempo), 2);
        chk("pre_reset_jogada", 16'(bus.jogada), 1);
        chk("pre_reset_reg", 16'(bus.db_jogada), 16'h4);
        #2 reset = 1;
        #1;
        chk("async_reset_E", 16'(bus.db_contagem), 0);
        chk("async_reset_Rod", 16'(bus.db_rodada), 0);
        chk("async_reset_T", 16'(bus.db_tempo), 0);
        chk("async_reset_P", 16'(bus.db_tempo_led), 0);
        chk("async_reset_reg", 16'(bus.db_jogada), 0);
        chk("async_reset_jogada", 16'(bus.jogada), 0);
        idle(); bus.botoes = 4'b0000;
        tick();
        reset = 0;

        // Seed word 0 and show it; then run the display timer to saturation
        bus.zeraR = 1;
        tick();
        bus.zeraR = 0; bus.sinal_led = 1;
        #1;
        chk("leds_seed", 16'(bus.leds), 16'h1);
        chk("mem0_seed", 16'(bus.db_memoria), 16'h1);
        bus.contaP = 1;
        repeat (998) tick();
        chk("fimP_998", 16'(bus.fimP), 0);
        tick();
        chk("fimP_999", 16'(bus.fimP), 1);
        chk("P_999", 16'(bus.db_tempo_led), 999);
        repeat (5) tick();
        chk("fimP_hold", 16'(bus.fimP), 1);
        chk("P_sat", 16'(bus.db_tempo_led), 999);
        bus.zeraP = 1;
        tick();
        bus.zeraP = 0; bus.contaP = 0; bus.sinal_led = 0;
        chk("fimP_zera", 16'(bus.fimP), 0);
        chk("P_zera", 16'(bus.db_tempo_led), 0);

        // Long press: single pulse two edges after the change, none on release
        bus.botoes = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("jogada_hold", 16'(bus.jogada), 16'(i == 2));
            if (i == 5) chk("leds_botoes", 16'(bus.leds), 16'h4);
        end
        bus.botoes = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("jogada_release", 16'(bus.jogada), 0);
        end
        bus.botoes = 4'b0001;
        tick();
        bus.botoes = 4'b0000;
        chk("short_press_e1", 16'(bus.jogada), 0);
        tick();
        chk("short_press_e2", 16'(bus.jogada), 1);
        tick();
        chk("short_press_e3", 16'(bus.jogada), 0);

        // Comparator at E=0 against the seeded word
        load_reg(4'b0001);
        chk("igual_match", 16'(bus.igual), 1);
        chk("reg_0001", 16'(bus.db_jogada), 16'h1);
        load_reg(4'b0010);
        chk("igual_miss", 16'(bus.igual), 0);

        // Write at E=1 and compare address with round
        bus.contaE = 1;
        tick();
        bus.contaE = 0;
        load_reg(4'b1000);
        bus.we = 1;
        tick();
        bus.we = 0;
        chk("E_1", 16'(bus.db_contagem), 1);
        chk("mem1", 16'(bus.db_memoria), 16'h8);
        chk("igual_mem1", 16'(bus.igual), 1);
        chk("eIgualRod_0", 16'(bus.enderecoIgualRodada), 0);
        bus.contaRod = 1;
        tick();
        bus.contaRod = 0;
        chk("eIgualRod_1", 16'(bus.enderecoIgualRodada), 1);
        chk("Rod_1", 16'(bus.db_rodada), 1);

        // leds mux table
        for (int i = 0; i < 6; i++) begin
            bus.botoes = led_tab[i].botoes;
            bus.sinal_led = led_tab[i].sinal_led;
            exp_q.push_back(16'(led_tab[i].exp_leds));
            #1;
            chk_pop("leds_tab", 16'(bus.leds));
        end
        bus.botoes = 4'b0000; bus.sinal_led = 0;

        // Round counter terminal and wrap
        bus.contaRod = 1;
        repeat (14) tick();
        bus.contaRod = 0;
        chk("fimRod_15", 16'(bus.fimRod), 1);
        chk("Rod_15", 16'(bus.db_rodada), 15);
        bus.contaRod = 1;
        tick();
        bus.contaRod = 0;
        chk("fimRod_wrap", 16'(bus.fimRod), 0);
        chk("Rod_wrap", 16'(bus.db_rodada), 0);

        // Fill all 16 words with random data, then read them back
        bus.zeraE = 1;
        tick();
        bus.zeraE = 0;
        for (int i = 0; i < 16; i++) begin
            val = 4'($urandom_range(0, 15));
            load_reg(val);
            bus.we = 1;
            tick();
            bus.we = 0;
            exp_q.push_back(16'(val));
            chk("fimE_walk", 16'(bus.fimE), 16'(i == 15));
            bus.contaE = 1;
            tick();
            bus.contaE = 0;
        end
        chk("fimE_drop", 16'(bus.fimE), 0);
        chk("E_wrap", 16'(bus.db_contagem), 0);
        for (int i = 0; i < 16; i++) begin
            chk_pop("mem_readback", 16'(bus.db_memoria));
            bus.contaE = 1;
            tick();
            bus.contaE = 0;
        end

        // zeraR together with we: E=3 writes both, E=0 seed wins
        load_reg(4'b1100);
        bus.we = 1;
        tick();
        bus.we = 0; bus.sinal_led = 1;
        #1;
        chk("mem0_overwrite", 16'(bus.leds), 16'hC);
        bus.sinal_led = 0;
        bus.contaE = 1;
        repeat (3) tick();
        bus.contaE = 0;
        load_reg(4'b1010);
        bus.zeraR = 1; bus.we = 1;
        tick();
        bus.zeraR = 0; bus.we = 0;
        chk("zeraR_we_E3_mem3", 16'(bus.db_memoria), 16'hA);
        chk("zeraR_we_E3_reg", 16'(bus.db_jogada), 0);
        bus.sinal_led = 1;
        #1;
        chk("zeraR_we_E3_mem0", 16'(bus.leds), 16'h1);
        bus.sinal_led = 0;
        bus.zeraE = 1;
        tick();
        bus.zeraE = 0;
        load_reg(4'b0110);
        bus.zeraR = 1; bus.we = 1;
        tick();
        bus.zeraR = 0; bus.we = 0;
        chk("zeraR_we_E0_mem0", 16'(bus.db_memoria), 16'h1);
        chk("zeraR_we_E0_reg", 16'(bus.db_jogada), 0);

        // Timeout counter terminal, saturation and clear priority
        bus.contaT = 1;
        repeat (4998) tick();
        chk("fimT_4998", 16'(bus.fimT), 0);
        tick();
        chk("fimT_4999", 16'(bus.fimT), 1);
        chk("T_4999", 16'(bus.db_tempo), 4999);
        repeat (3) tick();
        chk("fimT_hold", 16'(bus.fimT), 1);
        chk("T_sat", 16'(bus.db_tempo), 4999);
        bus.zeraT = 1;
        tick();
        bus.zeraT = 0;
        chk("fimT_zera", 16'(bus.fimT), 0);
        chk("T_zera", 16'(bus.db_tempo), 0);
        tick();
        bus.contaT = 0;
        chk("T_restart", 16'(bus.db_tempo), 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/fluxo_dados_exp7.md
Name: fluxo_dados_exp7

Overview:
Datapath for the memory-sequence game. It is driven by the game control unit's Moore outputs (zera*/conta*/registraR/we/sinal_led) and returns status flags to it (fimE, fimRod, fimT, fimP, igual, enderecoIgualRodada, jogada). It contains:
- address, round, timeout and display counters
- a play register
- a 16x4 sequence memory
- a comparator
- a button edge detector

Parameters:
- TIMEOUT, 5000, cycles allowed per play before fimT
- TEMPO_LED, 1000, cycles the initial play is shown (fimP)
- N_RODADAS, 16, rounds to win; fimRod when round counter = N_RODADAS-1 (range 1..16)
- JOGADA_INICIAL, 4'b0001, one-hot play written to address 0 on zeraR

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- botoes  in  4  raw player buttons, one-hot when valid
- zeraE, contaE  in  1 each  address counter clear/increment
- zeraRod, contaRod  in  1 each  round counter clear/increment
- zeraT, contaT  in  1 each  timeout counter clear/increment
- zeraP, contaP  in  1 each  display counter clear/increment
- zeraR, registraR  in  1 each  play register clear/load
- we  in  1  memory write enable
- sinal_led  in  1  show memory word 0 on leds
- jogada  out  1  one-cycle pulse on button press
- igual  out  1  mem[E] == play register
- enderecoIgualRodada  out  1  E == Rod
- fimE  out  1  E == 15
- fimRod  out  1  Rod == N_RODADAS-1
- fimT  out  1  timeout counter == TIMEOUT-1
- fimP  out  1  display counter == TEMPO_LED-1
- leds  out  4  player feedback
- db_contagem  out  4  E value
- db_rodada  out  4  Rod value
- db_jogada  out  4  play register
- db_memoria  out  4  mem[E]

Behaviour:
- Reset (async): E, Rod, T, P, play register, edge-detector flops all 0; jogada=0. Memory contents are not reset.
- All counters are synchronous. Zero has priority over count; count with zero=0 increments by 1.
- E and Rod are 4 bit and wrap 15->0. T and P hold at terminal value (saturate) while counting.
- fimT and fimP are combinational on count equality. They stay high while held at the terminal value, until zera.
- Timer widths are $clog2(TIMEOUT) and $clog2(TEMPO_LED), minimum 1.
- Edge detector:
  - Two-flop pipeline on any_btn = |botoes.
  - jogada = current & ~previous: exactly 1 cycle per press, regardless of hold length.
  - Latency: 2 cycles from botoes change to jogada.
  - Release produces no pulse.
- Play register: on registraR, loads botoes at that edge. zeraR clears it to 0 and has priority over registraR.
- Memory:
  - 16x4, asynchronous read at address E.
  - Synchronous write on we: mem[E] <= play register.
  - On a zeraR cycle, mem[0] <= JOGADA_INICIAL. If zeraR and we occur together, the zeraR write wins when E=0; otherwise both writes occur.
- Comparator: igual = (mem[E] == play register), purely combinational. It is valid the cycle after registraR.
- leds = sinal_led ? mem[0] : botoes.
- Simultaneous contaE on E=15: wraps to 0, and fimE drops the next cycle.
- Reset mid-operation: counters clear immediately. The control unit restarts from its initial state; the memory keeps stale words above address 0, which are overwritten as rounds progress.

Decomposition:
- Shared package holds:
  - widths: ADDR_W=4, DATA_W=4
  - the JOGADA_INICIAL default
  - a localparam for the memory depth 16
- Sub-modules:
  - one generic contador_m sub-module (parameter M; ports clock, reset, zera, conta, Q, fim), instantiated for E, Rod, T, P
  - sync_ram_16x4 and edge_detector as separate small modules

Test Plan:
- Reset with counters nonzero -> E=Rod=T=P=0, db_jogada=0, jogada=0 immediately (before the next clock).
- zeraR=1 for 1 cycle, then sinal_led=1 -> leds=4'b0001; contaP for 999 cycles -> fimP=1 on count 999 and stays 1.
- botoes=4'b0100 held 20 cycles -> jogada high exactly 1 cycle, 2 cycles after the press; no pulse on release.
- registraR with botoes=4'b0001, E=0 after zeraR -> igual=1; repeat with 4'b0010 -> igual=0.
- E=Rod=0; contaE then we with register 4'b1000 -> mem[1]=4'b1000 (db_memoria), enderecoIgualRodada=0; contaRod -> enderecoIgualRodada=1.
- contaT held 5000 cycles -> fimT=1 at count 4999 and saturates; zeraT together with contaT -> T=0, fimT=0.
